ps2_rx: RTL and testbench

//   PS/2 keyboard device-to-host receiver. Synchronises and filters the PS/2 clock.

---
 rtl/ps2_rx.sv | 114 +++++++++++
 tb/tb_ps2_rx.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx.sv
// rtl/ps2_rx.sv - PS/2 device-to-host frame receiver
// Synchronises and deglitches the pad clock, deserialises 11-bit frames, keeps the last two good bytes.
module ps2_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [15:0] code,
  output logic        status,
  output logic        err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t        state, state_next;
  logic [1:0]    clk_sync, data_sync;
  logic          filt, prev_filt, fall, data_bit;
  logic [FW-1:0] flt_cnt;
  logic [TW-1:0] to_cnt;
  logic [7:0]    shift;
  logic [2:0]    bit_cnt;
  logic          par_bit;
  logic          timeout, frame_good, frame_bad;

  assign fall     = prev_filt & ~filt;
  assign data_bit = data_sync[1];

  // Everything on the clock path resets high so leaving reset never looks like a falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      filt      <= 1'b1;
      prev_filt <= 1'b1;
      flt_cnt   <= '0;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      prev_filt <= filt;
      if (clk_sync[1] == filt) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
        filt    <= ~filt;
        flt_cnt <= '0;
      end else begin
        flt_cnt <= flt_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    frame_good = 1'b0;
    frame_bad  = 1'b0;
    timeout    = (state != IDLE) && !fall && (to_cnt == TW'(TIMEOUT_CYCLES - 1));
    if (timeout) begin
      state_next = IDLE;
    end else if (fall) begin
      case (state)
        IDLE:    if (!data_bit) state_next = DATA;
        DATA:    if (bit_cnt == 3'd7) state_next = PARITY;
        PARITY:  state_next = STOP;
        STOP: begin
          state_next = IDLE;
          // Odd parity: data plus parity bit must hold an odd number of ones.
          if (data_bit && (^{shift, par_bit})) frame_good = 1'b1;
          else                                 frame_bad  = 1'b1;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift   <= '0;
      bit_cnt <= '0;
      par_bit <= 1'b0;
      to_cnt  <= '0;
      code    <= '0;
      status  <= 1'b0;
      err     <= 1'b0;
    end else begin
      status <= frame_good;
      err    <= frame_bad | timeout;
      if (state == IDLE || fall || timeout) to_cnt <= '0;
      else                                  to_cnt <= to_cnt + 1'b1;
      if (fall) begin
        case (state)
          IDLE:   bit_cnt <= '0;
          DATA: begin
            shift   <= {data_bit, shift[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
          end
          PARITY: par_bit <= data_bit;
          default: ;
        endcase
      end
      if (frame_good) code <= {code[7:0], shift};
    end
  end

endmodule

// File: tb/tb_ps2_rx.sv
// tb/tb_ps2_rx.sv - self-checking bench for ps2_rx
// Frames are built from byte/parity/stop intent; a two-byte history model predicts code.
module tb_ps2_rx;

  localparam int FILTER_LEN     = 8;
  localparam int TIMEOUT_CYCLES = 2000;
  localparam int HALF           = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [15:0] code;
  logic        status, err;

  int errors = 0;
  int checks = 0;
  int st_cnt = 0;
  int er_cnt = 0;
  int both_cnt = 0;
  logic [7:0] m_old = 8'h00;
  logic [7:0] m_new = 8'h00;

  ps2_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .code(code), .status(status), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (status) st_cnt++;
    if (err) er_cnt++;
    if (status && err) both_cnt++;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] b, input logic par_err, input logic stop);
    logic par;
    par = ~(^b) ^ par_err;
    return {stop, par, b, 1'b0};
  endfunction

  function automatic void model_good(input logic [7:0] b);
    m_old = m_new;
    m_new = b;
  endfunction

  task automatic send_bits(input logic [10:0] frame, input int nbits, input int glitch_bit);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = frame[i];
      if (i == glitch_bit) begin
        wait_cycles(HALF / 2);
        ps2_clk = 1'b0;
        wait_cycles(FILTER_LEN - 1);
        ps2_clk = 1'b1;
        wait_cycles(HALF / 2 - (FILTER_LEN - 1));
      end else begin
        wait_cycles(HALF);
      end
      ps2_clk = 1'b0;
      wait_cycles(HALF);
      ps2_clk = 1'b1;
    end
    wait_cycles(HALF);
    ps2_data = 1'b1;
  endtask

  task automatic test_reset;
    wait_cycles(3);
    checks++; if (code !== 16'h0000) begin errors++; $display("FAIL reset_code: got %h expected 0000", code); end
    checks++; if (status !== 1'b0) begin errors++; $display("FAIL reset_status: got %b expected 0", status); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
    rst = 1'b0;
    wait_cycles(30);
    checks++; if (er_cnt + st_cnt !== 0) begin errors++; $display("FAIL reset_no_pulse: got %0d pulses expected 0", er_cnt + st_cnt); end
  endtask

  task automatic test_basic;
    int s0, e0;
    s0 = st_cnt; e0 = er_cnt;
    send_bits(make_frame(8'h16, 1'b0, 1'b1), 11, -1);
    model_good(8'h16);
    checks++; if (code !== 16'h0016) begin errors++; $display("FAIL basic_code: got %h expected 0016", code); end
    checks++; if (st_cnt - s0 !== 1) begin errors++; $display("FAIL basic_status: got %0d pulses expected 1", st_cnt - s0); end
    checks++; if (er_cnt - e0 !== 0) begin errors++; $display("FAIL basic_err: got %0d pulses expected 0", er_cnt - e0); end
  endtask

  task automatic test_pair;
    int s0;
    s0 = st_cnt;
    send_bits(make_frame(8'hF0, 1'b0, 1'b1), 11, -1);
    model_good(8'hF0);
    checks++; if (code !== 16'h16F0) begin errors++; $display("FAIL pair_first: got %h expected 16f0", code); end
    wait_cycles(HALF);
    send_bits(make_frame(8'h16, 1'b0, 1'b1), 11, -1);
    model_good(8'h16);
    checks++; if (code !== 16'hF016) begin errors++; $display("FAIL pair_code: got %h expected f016", code); end
    checks++; if (st_cnt - s0 !== 2) begin errors++; $display("FAIL pair_status: got %0d pulses expected 2", st_cnt - s0); end
  endtask

  task automatic test_bad_frames;
    int s0, e0;
    for (int k = 0; k < 2; k++) begin
      s0 = st_cnt; e0 = er_cnt;
      if (k == 0) send_bits(make_frame(8'h1E, 1'b1, 1'b1), 11, -1);
      else        send_bits(make_frame(8'h1E, 1'b0, 1'b0), 11, -1);
      checks++; if (er_cnt - e0 !== 1) begin errors++; $display("FAIL bad%0d_err: got %0d pulses expected 1", k, er_cnt - e0); end
      checks++; if (st_cnt - s0 !== 0) begin errors++; $display("FAIL bad%0d_status: got %0d pulses expected 0", k, st_cnt - s0); end
      checks++; if (code !== {m_old, m_new}) begin errors++; $display("FAIL bad%0d_code: got %h expected %h", k, code, {m_old, m_new}); end
      wait_cycles(HALF);
    end
  endtask

  task automatic test_glitch;
    int s0, e0;
    s0 = st_cnt; e0 = er_cnt;
    send_bits(make_frame(8'h5A, 1'b0, 1'b1), 11, 4);
    model_good(8'h5A);
    checks++; if (code !== {m_old, m_new}) begin errors++; $display("FAIL glitch_code: got %h expected %h", code, {m_old, m_new}); end
    checks++; if (st_cnt - s0 !== 1) begin errors++; $display("FAIL glitch_status: got %0d pulses expected 1", st_cnt - s0); end
    checks++; if (er_cnt - e0 !== 0) begin errors++; $display("FAIL glitch_err: got %0d pulses expected 0", er_cnt - e0); end
  endtask

  task automatic test_timeout;
    int s0, e0;
    s0 = st_cnt; e0 = er_cnt;
    send_bits(make_frame(8'hA5, 1'b0, 1'b1), 5, -1);
    wait_cycles(TIMEOUT_CYCLES + 200);
    checks++; if (er_cnt - e0 !== 1) begin errors++; $display("FAIL timeout_err: got %0d pulses expected 1", er_cnt - e0); end
    checks++; if (st_cnt - s0 !== 0) begin errors++; $display("FAIL timeout_status: got %0d pulses expected 0", st_cnt - s0); end
    send_bits(make_frame(8'h45, 1'b0, 1'b1), 11, -1);
    model_good(8'h45);
    checks++; if (code[7:0] !== 8'h45) begin errors++; $display("FAIL timeout_next: got %h expected 45", code[7:0]); end
    checks++; if (st_cnt - s0 !== 1) begin errors++; $display("FAIL timeout_next_status: got %0d pulses expected 1", st_cnt - s0); end
  endtask

  task automatic test_reset_mid;
    int s0;
    send_bits(make_frame(8'h3C, 1'b0, 1'b1), 4, -1);
    #2 rst = 1'b1;
    #1;
    m_old = 8'h00; m_new = 8'h00;
    checks++; if (code !== 16'h0000) begin errors++; $display("FAIL rstmid_code: got %h expected 0000", code); end
    checks++; if (status !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL rstmid_flags: got %b%b expected 00", status, err); end
    wait_cycles(4);
    rst = 1'b0;
    wait_cycles(HALF);
    s0 = st_cnt;
    send_bits(make_frame(8'h26, 1'b0, 1'b1), 11, -1);
    model_good(8'h26);
    checks++; if (code !== 16'h0026) begin errors++; $display("FAIL rstmid_code_after: got %h expected 0026", code); end
    checks++; if (st_cnt - s0 !== 1) begin errors++; $display("FAIL rstmid_status: got %0d pulses expected 1", st_cnt - s0); end
  endtask

  task automatic test_random;
    int s0, e0, kind, glitch;
    logic [7:0] b;
    for (int n = 0; n < 12; n++) begin
      b = 8'($urandom_range(0, 255));
      kind = $urandom_range(0, 3);
      glitch = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 10) : -1;
      s0 = st_cnt; e0 = er_cnt;
      send_bits(make_frame(b, kind == 1, kind != 2), 11, glitch);
      if (kind != 1 && kind != 2) model_good(b);
      checks++; if (code !== {m_old, m_new}) begin errors++; $display("FAIL rand%0d_code: got %h expected %h", n, code, {m_old, m_new}); end
      checks++; if (st_cnt - s0 !== ((kind == 1 || kind == 2) ? 0 : 1)) begin errors++; $display("FAIL rand%0d_status: got %0d pulses kind %0d", n, st_cnt - s0, kind); end
      checks++; if (er_cnt - e0 !== ((kind == 1 || kind == 2) ? 1 : 0)) begin errors++; $display("FAIL rand%0d_err: got %0d pulses kind %0d", n, er_cnt - e0, kind); end
      wait_cycles($urandom_range(0, HALF));
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_pair;
    test_bad_frames;
    test_glitch;
    test_timeout;
    test_reset_mid;
    test_random;
    checks++; if (both_cnt !== 0) begin errors++; $display("FAIL exclusive: got %0d cycles with status and err expected 0", both_cnt); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
